// File: rtl/pending_arbiter_pkg.sv
// rtl/pending_arbiter_pkg.sv - shared types for the pending-request arbiter
package pending_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/prioritydecoder.sv
// rtl/prioritydecoder.sv - combinational highest-set-index decoder
module prioritydecoder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     valid_o
);

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) begin
        idx_o   = ($clog2(WIDTH))'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_arbiter.sv
// rtl/pending_arbiter.sv - latches request pulses and offers the highest eligible line
module pending_arbiter
  import pending_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pending_o,
  output logic             dropped_o,
  input  logic             clr_dropped_i
);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  out_idx_q, out_idx_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             dropped_q, dropped_d;

  logic [IDXW-1:0]  dec_idx;
  logic             dec_valid;
  logic             ack;
  logic [WIDTH-1:0] clr_vec;

  prioritydecoder #(.WIDTH(WIDTH)) u_dec (
    .in_i    (pending_q & mask_i),
    .idx_o   (dec_idx),
    .valid_o (dec_valid)
  );

  // A new request on the acknowledged line re-arms it and is not a drop.
  always_comb begin
    ack     = (state_q == OFFER) && out_ready;
    clr_vec = '0;
    if (ack) begin
      clr_vec[out_idx_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | req_i;
    dropped_d = (|(req_i & pending_q & ~clr_vec)) | (dropped_q & ~clr_dropped_i);
  end

  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    case (state_q)
      IDLE: begin
        if (dec_valid) begin
          out_idx_d = dec_idx;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_idx_q <= '0;
      pending_q <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_idx_q <= out_idx_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign out_idx   = out_idx_q;
  assign out_valid = (state_q == OFFER);
  assign pending_o = pending_q;
  assign dropped_o = dropped_q;

endmodule

// File: tb/tb_pending_arbiter.sv
// tb/tb_pending_arbiter.sv - scoreboard bench for pending_arbiter
module tb_pending_arbiter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] req_i = '0;
  logic [WIDTH-1:0] mask_i = '0;
  logic             out_ready = 1'b0;
  logic             clr_dropped_i = 1'b0;
  logic [1:0]       out_idx;
  logic             out_valid;
  logic [WIDTH-1:0] pending_o;
  logic             dropped_o;

  pending_arbiter #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .mask_i        (mask_i),
    .out_idx       (out_idx),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pending_o     (pending_o),
    .dropped_o     (dropped_o),
    .clr_dropped_i (clr_dropped_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: set of pending lines, current offer, expected-grant queue.
  bit [WIDTH-1:0] m_pend;
  bit             m_drop;
  bit             m_valid;
  int             m_idx;
  int             exp_q[$];
  int             cyc_cnt;
  int             log_idx[$];
  int             log_cyc[$];

  bit [WIDTH-1:0] np;
  bit             m_hit;
  bit             m_ack;
  int             sel;

  always @(posedge clk) begin
    cyc_cnt++;
    if (!rst_n) begin
      m_pend  = '0;
      m_drop  = 1'b0;
      m_valid = 1'b0;
      m_idx   = 0;
      exp_q.delete();
    end else begin
      m_ack = m_valid && out_ready;
      sel = -1;
      if (!m_valid) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (m_pend[i] && mask_i[i]) begin
            sel = i;
            break;
          end
        end
      end
      np = m_pend;
      if (m_ack) np[m_idx] = 1'b0;
      m_hit = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (req_i[i]) begin
          if (np[i]) m_hit = 1'b1;
          np[i] = 1'b1;
        end
      end
      m_pend = np;
      if (m_hit) m_drop = 1'b1;
      else if (clr_dropped_i) m_drop = 1'b0;
      if (m_ack) m_valid = 1'b0;
      else if (sel >= 0) begin
        m_valid = 1'b1;
        m_idx   = sel;
        exp_q.push_back(sel);
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("pending_o", {28'b0, pending_o}, {28'b0, m_pend});
    check("dropped_o", {31'b0, dropped_o}, {31'b0, m_drop});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("grant_expected", 32'd0, 32'd1);
      end else begin
        check("out_idx", {30'b0, out_idx}, exp_q[0]);
        if (out_ready && rst_n) begin
          void'(exp_q.pop_front());
          log_idx.push_back(int'(out_idx));
          log_cyc.push_back(cyc_cnt);
        end
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] m, input logic rdy, input logic c);
    req_i = r;
    mask_i = m;
    out_ready = rdy;
    clr_dropped_i = c;
    @(posedge clk);
    #1;
    req_i = '0;
    clr_dropped_i = 1'b0;
  endtask

  task automatic clear_log();
    log_idx.delete();
    log_cyc.delete();
  endtask

  initial begin
    cyc(4'h0, 4'hF, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b1, 1'b0);
    check("rst_out_idx", {30'b0, out_idx}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pending", {28'b0, pending_o}, 32'd0);
    rst_n = 1'b1;

    // single request: offer appears two edges after the pulse
    cyc(4'b0010, 4'hF, 1'b1, 1'b0);
    check("s1_pending", {28'b0, pending_o}, 32'b0010);
    check("s1_valid_c2", {31'b0, out_valid}, 32'd0);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    check("s1_valid_c3", {31'b0, out_valid}, 32'd1);
    check("s1_idx", {30'b0, out_idx}, 32'd1);
    cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    check("s1_pending_after", {28'b0, pending_o}, 32'd0);

    // three simultaneous requests drain highest first, two cycles apart
    clear_log();
    cyc(4'b1011, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    check("s2_ngrants", log_idx.size(), 32'd3);
    if (log_idx.size() == 3) begin
      check("s2_g0", log_idx[0], 32'd3);
      check("s2_g1", log_idx[1], 32'd1);
      check("s2_g2", log_idx[2], 32'd0);
      check("s2_gap0", log_cyc[1] - log_cyc[0], 32'd2);
      check("s2_gap1", log_cyc[2] - log_cyc[1], 32'd2);
    end

    // stalled offer holds its index across new requests and mask changes
    clear_log();
    cyc(4'b0100, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    cyc(4'b1000, 4'hF, 1'b0, 1'b0);
    cyc(4'b0000, 4'h0, 1'b0, 1'b0);
    cyc(4'b0000, 4'h8, 1'b0, 1'b0);
    cyc(4'b0000, 4'h0, 1'b0, 1'b0);
    check("s3_hold_valid", {31'b0, out_valid}, 32'd1);
    check("s3_hold_idx", {30'b0, out_idx}, 32'd2);
    for (int i = 0; i < 6; i++) cyc(4'b0000, 4'hF, 1'b1, 1'b0);
    check("s3_ngrants", log_idx.size(), 32'd2);
    if (log_idx.size() == 2) begin
      check("s3_g0", log_idx[0], 32'd2);
      check("s3_g1", log_idx[1], 32'd3);
    end

    // mask limits eligibility to line 0
    clear_log();
    cyc(4'b0101, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(4'b0000, 4'b0001, 1'b1, 1'b0);
    check("s4_pending", {28'b0, pending_o}, 32'b0100);
    check("s4_ngrants", log_idx.size(), 32'd1);
    if (log_idx.size() == 1) check("s4_g0", log_idx[0], 32'd0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 4'hF, 1'b1, 1'b0);

    // drop flag, clear, and re-request in the acknowledge cycle
    cyc(4'b0010, 4'h0, 1'b0, 1'b0);
    cyc(4'b0010, 4'h0, 1'b0, 1'b0);
    check("s5_dropped", {31'b0, dropped_o}, 32'd1);
    cyc(4'b0000, 4'h0, 1'b0, 1'b1);
    check("s5_cleared", {31'b0, dropped_o}, 32'd0);
    cyc(4'b0000, 4'hF, 1'b0, 1'b0);
    check("s5_offer_idx", {30'b0, out_idx}, 32'd1);
    cyc(4'b0010, 4'hF, 1'b1, 1'b0);
    check("s5_rearm", {28'b0, pending_o}, 32'b0010);
    check("s5_no_drop", {31'b0, dropped_o}, 32'd0);
    for (int i = 0; i < 4; i++) cyc(4'b0000, 4'hF, 1'b1, 1'b0);

    // reset in the middle of an offer
    cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    cyc(4'b0001, 4'hF, 1'b0, 1'b0);
    check("s6_offer", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    cyc(4'b0100, 4'hF, 1'b1, 1'b0);
    rst_n = 1'b1;
    check("s6_valid", {31'b0, out_valid}, 32'd0);
    check("s6_pending", {28'b0, pending_o}, 32'd0);
    check("s6_dropped", {31'b0, dropped_o}, 32'd0);
    check("s6_idx", {30'b0, out_idx}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0));
    end
    rst_n = 1'b1;
    cyc(4'h0, 4'hF, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pending_arbiter.md
PENDING_ARBITER -- requirements
Module: pending_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of request lines; legal values are powers of two, 2 or greater.
REQ-002 SHALL have localparam IDXW = $clog2(WIDTH), the index width; it matches the priority decoder output width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port req_i, input, WIDTH, single-cycle request pulses, one bit per line.
REQ-006 SHALL have port mask_i, input, WIDTH, enable mask; 1 = line eligible for grant.
REQ-007 SHALL have port out_idx, output, IDXW, offered line index.
REQ-008 SHALL have port out_valid, output, 1, offer valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the offer.
REQ-010 SHALL have port pending_o, output, WIDTH, current pending register.
REQ-011 SHALL have port dropped_o, output, 1, sticky flag: a request hit an already-pending line.
REQ-012 SHALL have port clr_dropped_i, input, 1, clears dropped_o.

Function
REQ-013 SHALL set pending[i] on the clock edge where req_i[i]=1, regardless of mask_i.
REQ-014 SHALL set dropped_o when req_i[i]=1 while pending[i]=1 and that bit is not being cleared in the same cycle.
REQ-015 SHALL give dropped set priority over clr_dropped_i when both occur in the same cycle.
REQ-016 SHALL implement a two-state FSM: IDLE and OFFER.
REQ-017 SHALL, in IDLE with (pending & mask_i) != 0, register out_idx = highest set index of (pending & mask_i), then move to OFFER.
REQ-018 SHALL, in IDLE with (pending & mask_i) == 0, remain in IDLE.
REQ-019 SHALL drive out_valid=1 exactly when the FSM is in OFFER; out_valid is a registered output.
REQ-020 SHALL hold out_idx stable while out_valid=1 and out_ready=0; changes to mask_i or req_i do not withdraw or alter the offer.
REQ-021 SHALL, on a cycle with out_valid=1 and out_ready=1, clear pending[out_idx] and return to IDLE at that edge.
REQ-022 SHALL keep pending[out_idx] set when req_i[out_idx]=1 arrives in the same cycle as the acknowledge; set wins and is not counted as a drop.
REQ-023 SHALL give a latency of 2 cycles from a req_i pulse on an idle, unmasked, empty block to out_valid=1.
REQ-024 SHALL give a throughput of at most one grant per 2 cycles, with one IDLE cycle between offers.
REQ-025 SHALL ignore out_ready while in IDLE.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, clear pending to 0, dropped_o to 0, out_idx to 0, out_valid to 0 and the FSM to IDLE, including mid-offer.
REQ-027 SHALL ignore req_i during any cycle where rst_n=0.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, OFFER) in a shared package, pending_arbiter_pkg.
REQ-029 SHALL implement highest-index selection by instantiating the existing combinational prioritydecoder sub-module on (pending & mask_i); no other sub-module.

Verification
REQ-030 SHALL verify: WIDTH=4, req_i=4'b0010 at cycle 1, mask=4'hF, ready=1 -> out_valid=1 with out_idx=1 at cycle 3, and pending returns to 0 after the acknowledge.
REQ-031 SHALL verify: req_i=4'b1011 in one cycle, ready=1 -> grants arrive in order 3, 1, 0, spaced 2 cycles apart.
REQ-032 SHALL verify: offer idx=2 with ready=0 for 5 cycles while req_i=4'b1000 arrives -> out_idx stays 2; the next grant is 3.
REQ-033 SHALL verify: mask=4'b0001 with pending=4'b0101 -> only idx 0 is granted; pending_o stays 4'b0100.
REQ-034 SHALL verify: req_i[1] pulsed twice before grant -> dropped_o=1; clr_dropped_i pulse -> 0; req on acked bit in the ack cycle -> pending stays 1 and dropped_o stays 0.
REQ-035 SHALL verify: rst_n=0 during OFFER -> the next cycle shows out_valid=0, pending_o=0, dropped_o=0.
